// File: rtl/gf_pkg.sv
// Shared types and default sizes for the branch resolution queue.
package gf_pkg;

    localparam int GF_BRQ_DEPTH  = 8;
    localparam int GF_BRQ_ADDR_W = 32;

    typedef struct packed {
        logic                     pred_taken;
        logic [GF_BRQ_ADDR_W-1:0] alt_pc;
    } brq_entry_t;

    typedef enum logic {
        BRQ_RUN   = 1'b0,
        BRQ_FLUSH = 1'b1
    } brq_state_e;

endpackage

// File: rtl/gf_brq_fifo.sv
// Circular buffer of branch entries; clear beats push/pop, head entry readable combinationally.
module gf_brq_fifo
    import gf_pkg::*;
#(
    parameter int  DEPTH   = GF_BRQ_DEPTH,
    parameter type entry_t = brq_entry_t,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  entry_t           wr_data,
    output entry_t           rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) tail_reg <= tail_reg + PTR_W'(1);
            if (pop)  head_reg <= head_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage has no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (push && !clear && !rst) mem[tail_reg] <= wr_data;
    end

    assign rd_data = mem[head_reg];
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;

endmodule

// File: rtl/gf_brq.sv
// Branch resolution queue: in-order predicted-branch tracking, predictor update strobe and mispredict flush.
// Optional statistics counters are compiled in with GF_BRQ_STATS_EN.
module gf_brq
    import gf_pkg::*;
#(
    parameter int  DEPTH  = GF_BRQ_DEPTH,
    parameter int  ADDR_W = GF_BRQ_ADDR_W,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_sig_push,
    input  logic              i_sig_pred_taken,
    input  logic [ADDR_W-1:0] i_dat_alt_pc,
    output logic              o_sig_full,
    output logic              o_sig_empty,
    output logic [CNT_W-1:0]  o_dat_count,
    input  logic              i_sig_resolve,
    input  logic              i_sig_act_taken,
    output logic              o_sig_cur_is_b,
    output logic              o_sig_cur_b_taken,
    output logic              o_sig_flush,
    output logic [ADDR_W-1:0] o_dat_redirect_pc,
`ifdef GF_BRQ_STATS_EN
    output logic [31:0]       o_dat_resolved_cnt,
    output logic [31:0]       o_dat_mispred_cnt,
`endif
    input  logic              i_sig_redirect_ack
);

    typedef struct packed {
        logic              pred_taken;
        logic [ADDR_W-1:0] alt_pc;
    } entry_t;

    brq_state_e        state_reg;
    logic              cur_is_b_reg;
    logic              cur_b_taken_reg;
    logic [ADDR_W-1:0] redirect_pc_reg;

    entry_t            head_entry;
    entry_t            push_entry;
    logic              fifo_full;
    logic              fifo_empty;
    logic              resolve_ok;
    logic              mispred;
    logic              push_ok;
    logic              pop_ok;

    assign push_entry = '{pred_taken: i_sig_pred_taken, alt_pc: i_dat_alt_pc};

    assign resolve_ok = (state_reg == BRQ_RUN) && i_sig_resolve && !fifo_empty;
    assign mispred    = resolve_ok && (i_sig_act_taken != head_entry.pred_taken);
    assign pop_ok     = resolve_ok && !mispred;
    // A pop in the same cycle frees the slot, so a full queue can still accept.
    assign push_ok    = (state_reg == BRQ_RUN) && i_sig_push && !mispred
                        && (!fifo_full || pop_ok);

    gf_brq_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_ok),
        .pop     (pop_ok),
        .clear   (mispred),
        .wr_data (push_entry),
        .rd_data (head_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (o_dat_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= BRQ_RUN;
            cur_is_b_reg    <= 1'b0;
            cur_b_taken_reg <= 1'b0;
            redirect_pc_reg <= '0;
        end else begin
            cur_is_b_reg    <= resolve_ok;
            cur_b_taken_reg <= resolve_ok && i_sig_act_taken;
            case (state_reg)
                BRQ_RUN: begin
                    if (mispred) begin
                        state_reg       <= BRQ_FLUSH;
                        redirect_pc_reg <= head_entry.alt_pc;
                    end
                end
                BRQ_FLUSH: begin
                    if (i_sig_redirect_ack) state_reg <= BRQ_RUN;
                end
                default: state_reg <= BRQ_RUN;
            endcase
        end
    end

`ifdef GF_BRQ_STATS_EN
    logic [31:0] resolved_cnt_reg;
    logic [31:0] mispred_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            resolved_cnt_reg <= '0;
            mispred_cnt_reg  <= '0;
        end else begin
            if (resolve_ok && resolved_cnt_reg != '1) resolved_cnt_reg <= resolved_cnt_reg + 32'd1;
            if (mispred && mispred_cnt_reg != '1)     mispred_cnt_reg  <= mispred_cnt_reg + 32'd1;
        end
    end

    assign o_dat_resolved_cnt = resolved_cnt_reg;
    assign o_dat_mispred_cnt  = mispred_cnt_reg;
`endif

    assign o_sig_full        = fifo_full;
    assign o_sig_empty       = fifo_empty;
    assign o_sig_cur_is_b    = cur_is_b_reg;
    assign o_sig_cur_b_taken = cur_b_taken_reg;
    assign o_sig_flush       = (state_reg == BRQ_FLUSH);
    assign o_dat_redirect_pc = redirect_pc_reg;

endmodule

// File: tb/tb_gf_brq.sv
// Directed self-checking bench for gf_brq; statistics checks follow GF_BRQ_STATS_EN.
module tb_gf_brq;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              push, pred, resolve, act, ack;
    logic [ADDR_W-1:0] alt_pc;
    logic              full, empty, is_b, b_taken, flush;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] redirect;
`ifdef GF_BRQ_STATS_EN
    logic [31:0]       resolved_cnt, mispred_cnt;
`endif

    int tests_run = 0;
    int fails     = 0;

    always #5 clk = ~clk;

    gf_brq #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk                (clk),
        .rst                (rst),
        .i_sig_push         (push),
        .i_sig_pred_taken   (pred),
        .i_dat_alt_pc       (alt_pc),
        .o_sig_full         (full),
        .o_sig_empty        (empty),
        .o_dat_count        (count),
        .i_sig_resolve      (resolve),
        .i_sig_act_taken    (act),
        .o_sig_cur_is_b     (is_b),
        .o_sig_cur_b_taken  (b_taken),
        .o_sig_flush        (flush),
        .o_dat_redirect_pc  (redirect),
`ifdef GF_BRQ_STATS_EN
        .o_dat_resolved_cnt (resolved_cnt),
        .o_dat_mispred_cnt  (mispred_cnt),
`endif
        .i_sig_redirect_ack (ack)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push = 1'b0; pred = 1'b0; alt_pc = '0; resolve = 1'b0; act = 1'b0; ack = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tests_run++; if (full !== 1'b0)     begin fails++; $display("FAIL reset_full: got %b want 0", full); end
        tests_run++; if (empty !== 1'b1)    begin fails++; $display("FAIL reset_empty: got %b want 1", empty); end
        tests_run++; if (count !== 4'd0)    begin fails++; $display("FAIL reset_count: got %0d want 0", count); end
        tests_run++; if (is_b !== 1'b0)     begin fails++; $display("FAIL reset_is_b: got %b want 0", is_b); end
        tests_run++; if (b_taken !== 1'b0)  begin fails++; $display("FAIL reset_b_taken: got %b want 0", b_taken); end
        tests_run++; if (flush !== 1'b0)    begin fails++; $display("FAIL reset_flush: got %b want 0", flush); end
        tests_run++; if (redirect !== '0)   begin fails++; $display("FAIL reset_redirect: got %h want 0", redirect); end
`ifdef GF_BRQ_STATS_EN
        tests_run++; if (resolved_cnt !== 32'd0) begin fails++; $display("FAIL reset_resolved_cnt: got %0d want 0", resolved_cnt); end
        tests_run++; if (mispred_cnt !== 32'd0)  begin fails++; $display("FAIL reset_mispred_cnt: got %0d want 0", mispred_cnt); end
`endif
        $display("[TB] reset done");
    endtask

    // Entries 0..7 carry pred = i[0], alt = 0x200+i; the 9th push must be dropped.
    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            push = 1'b1; pred = i[0]; alt_pc = 32'h200 + i;
            tick();
            tests_run++; if (count !== 4'(i + 1)) begin fails++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1); end
            $display("[TB] push %0d pred=%b alt=%h count=%0d", i, pred, alt_pc, count);
        end
        tests_run++; if (full !== 1'b1)  begin fails++; $display("FAIL fill_full: got %b want 1", full); end
        tests_run++; if (empty !== 1'b0) begin fails++; $display("FAIL fill_empty: got %b want 0", empty); end
        push = 1'b1; pred = 1'b1; alt_pc = 32'hBAD;
        tick();
        idle();
        tests_run++; if (count !== 4'd8) begin fails++; $display("FAIL overflow_count: got %0d want 8", count); end
        $display("[TB] overflow push count=%0d", count);
    endtask

    task automatic test_full_push_resolve();
        push = 1'b1; pred = 1'b0; alt_pc = 32'h300; resolve = 1'b1; act = 1'b0;
        tick();
        idle();
        tests_run++; if (count !== 4'd8)    begin fails++; $display("FAIL full_pr_count: got %0d want 8", count); end
        tests_run++; if (is_b !== 1'b1)     begin fails++; $display("FAIL full_pr_is_b: got %b want 1", is_b); end
        tests_run++; if (b_taken !== 1'b0)  begin fails++; $display("FAIL full_pr_taken: got %b want 0", b_taken); end
        tests_run++; if (flush !== 1'b0)    begin fails++; $display("FAIL full_pr_flush: got %b want 0", flush); end
        $display("[TB] push+resolve on full count=%0d strobe=%b", count, is_b);
        for (int k = 1; k < DEPTH; k++) begin
            resolve = 1'b1; act = k[0];
            tick();
            tests_run++; if (is_b !== 1'b1 || b_taken !== k[0] || flush !== 1'b0 || count !== 4'(DEPTH - k))
                begin fails++; $display("FAIL drain[%0d]: got is_b=%b taken=%b flush=%b count=%0d want 1 %b 0 %0d", k, is_b, b_taken, flush, count, k[0], DEPTH - k); end
            $display("[TB] resolve %0d act=%b count=%0d", k, act, count);
        end
        resolve = 1'b1; act = 1'b0;
        tick();
        idle();
        tests_run++; if (is_b !== 1'b1 || flush !== 1'b0 || empty !== 1'b1)
            begin fails++; $display("FAIL drain_pushed: got is_b=%b flush=%b empty=%b want 1 0 1", is_b, flush, empty); end
        tick();
        tests_run++; if (is_b !== 1'b0) begin fails++; $display("FAIL strobe_width: got %b want 0", is_b); end
        $display("[TB] pushed entry resolved count=%0d", count);
    endtask

    task automatic test_mispredict_flush();
        push = 1'b1; pred = 1'b1; alt_pc = 32'h100;
        tick();
        idle();
        resolve = 1'b1; act = 1'b0;
        tick();
        idle();
        tests_run++; if (is_b !== 1'b1)        begin fails++; $display("FAIL mp_is_b: got %b want 1", is_b); end
        tests_run++; if (b_taken !== 1'b0)     begin fails++; $display("FAIL mp_taken: got %b want 0", b_taken); end
        tests_run++; if (flush !== 1'b1)       begin fails++; $display("FAIL mp_flush: got %b want 1", flush); end
        tests_run++; if (redirect !== 32'h100) begin fails++; $display("FAIL mp_redirect: got %h want 100", redirect); end
        tests_run++; if (count !== 4'd0)       begin fails++; $display("FAIL mp_count: got %0d want 0", count); end
        $display("[TB] mispredict flush=%b redirect=%h", flush, redirect);
        // Three flush cycles with ignored traffic: two pushes then a resolve.
        push = 1'b1; pred = 1'b0; alt_pc = 32'h55;
        tick(); tick();
        push = 1'b0; resolve = 1'b1; act = 1'b1;
        tick();
        idle();
        tests_run++; if (count !== 4'd0 || is_b !== 1'b0) begin fails++; $display("FAIL flush_ignore: got count=%0d is_b=%b want 0 0", count, is_b); end
        tests_run++; if (flush !== 1'b1 || redirect !== 32'h100) begin fails++; $display("FAIL flush_hold: got flush=%b redirect=%h want 1 100", flush, redirect); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tests_run++; if (flush !== 1'b0) begin fails++; $display("FAIL ack_clear: got %b want 0", flush); end
        push = 1'b1; pred = 1'b0; alt_pc = 32'h77;
        tick();
        idle();
        tests_run++; if (count !== 4'd1) begin fails++; $display("FAIL post_ack_push: got count=%0d want 1", count); end
        resolve = 1'b1; act = 1'b0;
        tick();
        idle();
        tests_run++; if (is_b !== 1'b1 || flush !== 1'b0 || count !== 4'd0)
            begin fails++; $display("FAIL post_ack_resolve: got is_b=%b flush=%b count=%0d want 1 0 0", is_b, flush, count); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tests_run++; if (flush !== 1'b0) begin fails++; $display("FAIL ack_in_run: got flush=%b want 0", flush); end
        $display("[TB] flush released, post-ack push accepted");
    endtask

    task automatic test_back_to_back();
        logic [2:0] pat;
        pat = 3'b101;
        resolve = 1'b1; act = 1'b1;
        tick();
        idle();
        tests_run++; if (is_b !== 1'b0 || flush !== 1'b0 || empty !== 1'b1)
            begin fails++; $display("FAIL empty_resolve: got is_b=%b flush=%b empty=%b want 0 0 1", is_b, flush, empty); end
        for (int i = 0; i < 3; i++) begin
            push = 1'b1; pred = pat[i]; alt_pc = 32'h400 + i;
            tick();
        end
        idle();
        tests_run++; if (count !== 4'd3) begin fails++; $display("FAIL b2b_count: got %0d want 3", count); end
        for (int i = 0; i < 3; i++) begin
            resolve = 1'b1; act = pat[i];
            tick();
            tests_run++; if (is_b !== 1'b1 || b_taken !== pat[i] || flush !== 1'b0)
                begin fails++; $display("FAIL b2b[%0d]: got is_b=%b taken=%b flush=%b want 1 %b 0", i, is_b, b_taken, flush, pat[i]); end
            $display("[TB] b2b resolve %0d taken=%b", i, b_taken);
        end
        idle();
        tick();
        tests_run++; if (is_b !== 1'b0 || empty !== 1'b1) begin fails++; $display("FAIL b2b_end: got is_b=%b empty=%b want 0 1", is_b, empty); end
`ifdef GF_BRQ_STATS_EN
        tests_run++; if (resolved_cnt !== 32'd14) begin fails++; $display("FAIL stats_resolved: got %0d want 14", resolved_cnt); end
        tests_run++; if (mispred_cnt !== 32'd1)   begin fails++; $display("FAIL stats_mispred: got %0d want 1", mispred_cnt); end
`endif
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            push = 1'b1; pred = 1'b1; alt_pc = 32'h500 + i;
            tick();
        end
        idle();
        tests_run++; if (count !== 4'd4) begin fails++; $display("FAIL mid_fill: got %0d want 4", count); end
        // Reset lands on the same edge as a mispredicting resolve.
        resolve = 1'b1; act = 1'b0; rst = 1'b1;
        tick();
        idle();
        rst = 1'b0;
        tests_run++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0)
            begin fails++; $display("FAIL mid_queue: got count=%0d empty=%b full=%b want 0 1 0", count, empty, full); end
        tests_run++; if (is_b !== 1'b0 || b_taken !== 1'b0 || flush !== 1'b0 || redirect !== '0)
            begin fails++; $display("FAIL mid_outputs: got is_b=%b taken=%b flush=%b redirect=%h want 0 0 0 0", is_b, b_taken, flush, redirect); end
        push = 1'b1; pred = 1'b1; alt_pc = 32'h600;
        tick();
        idle();
        resolve = 1'b1; act = 1'b0;
        tick();
        idle();
        tests_run++; if (flush !== 1'b1) begin fails++; $display("FAIL mid_flush_set: got %b want 1", flush); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++; if (flush !== 1'b0 || redirect !== '0 || is_b !== 1'b0)
            begin fails++; $display("FAIL mid_flush_reset: got flush=%b redirect=%h is_b=%b want 0 0 0", flush, redirect, is_b); end
`ifdef GF_BRQ_STATS_EN
        tests_run++; if (resolved_cnt !== 32'd0 || mispred_cnt !== 32'd0)
            begin fails++; $display("FAIL mid_stats: got %0d %0d want 0 0", resolved_cnt, mispred_cnt); end
`endif
        $display("[TB] reset mid-operation done");
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_fill();
        test_full_push_resolve();
        test_mispredict_flush();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
